// File: rtl/uart_tx_frame.sv
// UART frame transmitter: one bit per clock, start / LSB-first data / optional parity / stop.
// Every output comes straight from a flop, and back-to-back frames hand off on the stop-bit edge.
module uart_tx_frame #(
  parameter int Data_Width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [Data_Width-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  Par_En,
  input  logic                  Par_Type,
  output logic                  TX_Out,
  output logic                  Busy
);

  localparam int CntW = (Data_Width > 1) ? $clog2(Data_Width) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Data_Width - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nxt;
  logic [Data_Width-1:0] data_q, data_nxt;
  logic                  par_en_q, par_en_nxt;
  logic                  par_type_q, par_type_nxt;
  logic [CntW-1:0]       cnt_q, cnt_nxt;
  logic                  tx_nxt, busy_nxt;
  logic                  par_bit;

  assign par_bit = par_type_q ? ~^data_q : ^data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      cnt_q      <= '0;
      TX_Out     <= 1'b1;
      Busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      data_q     <= data_nxt;
      par_en_q   <= par_en_nxt;
      par_type_q <= par_type_nxt;
      cnt_q      <= cnt_nxt;
      TX_Out     <= tx_nxt;
      Busy       <= busy_nxt;
    end
  end

  // tx_nxt is the bit that will sit on the line for the cycle after this edge
  always_comb begin
    state_nxt    = state;
    data_nxt     = data_q;
    par_en_nxt   = par_en_q;
    par_type_nxt = par_type_q;
    cnt_nxt      = cnt_q;
    tx_nxt       = 1'b1;
    busy_nxt     = 1'b0;

    unique case (state)
      IDLE: begin
        if (Data_Valid) begin
          data_nxt     = P_Data;
          par_en_nxt   = Par_En;
          par_type_nxt = Par_Type;
          state_nxt    = START;
          tx_nxt       = 1'b0;
          busy_nxt     = 1'b1;
        end
      end
      START: begin
        state_nxt = DATA;
        cnt_nxt   = '0;
        tx_nxt    = data_q[0];
        busy_nxt  = 1'b1;
      end
      DATA: begin
        busy_nxt = 1'b1;
        if (cnt_q == LastCnt) begin
          cnt_nxt = '0;
          if (par_en_q) begin
            state_nxt = PARITY;
            tx_nxt    = par_bit;
          end else begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_q + 1'b1;
          tx_nxt  = data_q[cnt_q + 1'b1];
        end
      end
      PARITY: begin
        state_nxt = STOP;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b1;
      end
      STOP: begin
        // A request on the stop edge starts the next frame with no idle bit
        if (Data_Valid) begin
          data_nxt     = P_Data;
          par_en_nxt   = Par_En;
          par_type_nxt = Par_Type;
          state_nxt    = START;
          tx_nxt       = 1'b0;
          busy_nxt     = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: a frame-queue model checked every cycle,
// plus literal line patterns for the directed words.
module tb_uart_tx_frame;

  logic       TX_CLK_TB = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_type = 1'b0;
  logic       tx_out;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  logic exp_q[$];
  logic exp_tx = 1'b1;
  logic exp_busy = 1'b0;

  uart_tx_frame #(.Data_Width(8)) dut (
    .clk       (TX_CLK_TB),
    .rst       (rst_n),
    .P_Data    (p_data),
    .Data_Valid(data_valid),
    .Par_En    (par_en),
    .Par_Type  (par_type),
    .TX_Out    (tx_out),
    .Busy      (busy)
  );

  always #5 TX_CLK_TB = ~TX_CLK_TB;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A frame is just the list of line levels it will produce, one per cycle
  task automatic buildFrame(input logic [7:0] d, input logic pe, input logic pt);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back(logic'(($countones(d) % 2) != 0) ^ pt);
    exp_q.push_back(1'b1);
  endtask

  // Model: a new frame is accepted only when nothing remains queued behind the current bit
  always @(posedge TX_CLK_TB or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_tx = 1'b1;
      exp_busy = 1'b0;
    end else begin
      if (exp_q.size() == 0 && data_valid) buildFrame(p_data, par_en, par_type);
      if (exp_q.size() > 0) begin
        exp_tx = exp_q.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_tx = 1'b1;
        exp_busy = 1'b0;
      end
    end
  end

  always @(negedge TX_CLK_TB) begin
    if (started) begin
      checkOutput("model_tx", {31'd0, tx_out}, {31'd0, exp_tx});
      checkOutput("model_busy", {31'd0, busy}, {31'd0, exp_busy});
    end
  end

  // Called on a negedge; returns on the negedge where the start bit is visible
  task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic pt);
    p_data = d;
    par_en = pe;
    par_type = pt;
    data_valid = 1'b1;
    @(posedge TX_CLK_TB);
    @(negedge TX_CLK_TB);
    data_valid = 1'b0;
  endtask

  task automatic captureBits(input int n, input int pulse_at, output logic [31:0] bits,
                             output int busy_cnt);
    bits = '0;
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      bits = {bits[30:0], tx_out};
      busy_cnt += int'(busy);
      if (i == pulse_at) begin
        data_valid = 1'b1;
        p_data = 8'hFF;
        par_en = ~par_en;
      end else if (i == pulse_at + 1) begin
        data_valid = 1'b0;
      end
      @(negedge TX_CLK_TB);
    end
  endtask

  initial begin
    logic [31:0] bits;
    int busy_cnt;
    logic [7:0] words [4] = '{8'h00, 8'hFF, 8'h81, 8'h6E};

    repeat (2) @(negedge TX_CLK_TB);
    checkOutput("reset_tx", {31'd0, tx_out}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    started = 1'b1;
    repeat (3) @(negedge TX_CLK_TB);

    $display("[TB] 0x55 odd parity");
    applyStimulus(8'h55, 1'b1, 1'b1);
    captureBits(11, -1, bits, busy_cnt);
    checkOutput("frame_55_odd", bits, 32'b01010101011);
    checkOutput("busy_len_55", busy_cnt, 32'd11);
    checkOutput("idle_after_55", {31'd0, busy}, 32'd0);

    $display("[TB] 0x5D even parity");
    applyStimulus(8'h5D, 1'b1, 1'b0);
    captureBits(11, -1, bits, busy_cnt);
    checkOutput("frame_5D_even", bits, 32'b01011101011);
    checkOutput("busy_len_5D", busy_cnt, 32'd11);

    $display("[TB] 0xC2 no parity, mid-frame request ignored");
    applyStimulus(8'hC2, 1'b0, 1'b0);
    captureBits(10, 3, bits, busy_cnt);
    checkOutput("frame_C2", bits, 32'b0010000111);
    checkOutput("busy_len_C2", busy_cnt, 32'd10);
    checkOutput("idle_after_C2_tx", {31'd0, tx_out}, 32'd1);
    checkOutput("idle_after_C2_busy", {31'd0, busy}, 32'd0);
    par_en = 1'b0;
    repeat (2) @(negedge TX_CLK_TB);

    $display("[TB] back-to-back 0xA5 then 0x3C");
    p_data = 8'hA5;
    par_en = 1'b0;
    par_type = 1'b0;
    data_valid = 1'b1;
    @(posedge TX_CLK_TB);
    @(negedge TX_CLK_TB);
    bits = '0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bits = {bits[30:0], tx_out};
      busy_cnt += int'(busy);
      if (i == 0) p_data = 8'h3C;
      if (i == 10) data_valid = 1'b0;
      @(negedge TX_CLK_TB);
    end
    checkOutput("frame_A5_3C", bits, 32'b01010010110001111001);
    checkOutput("busy_len_b2b", busy_cnt, 32'd20);
    checkOutput("idle_after_b2b", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge TX_CLK_TB);

    $display("[TB] async reset mid-frame");
    applyStimulus(8'h55, 1'b0, 1'b0);
    repeat (4) @(negedge TX_CLK_TB);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_tx", {31'd0, tx_out}, 32'd1);
    checkOutput("async_reset_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge TX_CLK_TB);
    rst_n = 1'b1;
    repeat (4) @(negedge TX_CLK_TB);
    checkOutput("post_reset_idle", {31'd0, busy}, 32'd0);

    $display("[TB] word sweep over parity configurations");
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < 3; c++) begin
        applyStimulus(words[w], logic'(c != 0), logic'(c == 2));
        repeat ((c != 0) ? 11 : 10) @(negedge TX_CLK_TB);
      end
    end
    repeat (2) @(negedge TX_CLK_TB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
